// File: rtl/pma_region_table_pkg.sv
// Shared types for the runtime-programmable physical-memory-attribute table.
package pma_region_table_pkg;

  typedef struct packed {
    logic non_idempotent;
    logic executable;
    logic cacheable;
  } pma_attr_t;

  typedef struct packed {
    logic       lock;
    logic [2:0] rsvd;
    logic       non_idem;
    logic       exec;
    logic       cache;
    logic       valid;
  } pma_ctrl_t;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'd0,
    FIELD_LENGTH = 2'd1,
    FIELD_CTRL   = 2'd2,
    FIELD_RSVD   = 2'd3
  } pma_field_e;

  localparam int         CTRL_LOCK_BIT = 7;
  // Reserved ctrl bits 6:4 are never stored, so they always read back as zero.
  localparam logic [7:0] CTRL_WMASK    = 8'h8F;

  function automatic pma_attr_t ctrl2attr(input pma_ctrl_t c);
    return '{non_idempotent: c.non_idem, executable: c.exec, cacheable: c.cache};
  endfunction

endpackage

// File: rtl/pma_region_table_if.sv
// Config port and lookup request/response channels of the PMA table.
interface pma_region_table_if #(
  parameter int NrRules   = 8,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
);
  import pma_region_table_pkg::*;

  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

  logic                 cfg_req;
  logic                 cfg_we;
  logic [IdxW+1:0]      cfg_addr;
  logic [DataWidth-1:0] cfg_wdata;
  logic                 cfg_gnt;
  logic                 cfg_rvalid;
  logic [DataWidth-1:0] cfg_rdata;
  logic                 cfg_err;

  logic                 lkp_valid;
  logic                 lkp_ready;
  logic [AddrWidth-1:0] lkp_addr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [IdxW-1:0]      rsp_idx;
  pma_attr_t            rsp_attr;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata, lkp_valid, lkp_addr, rsp_ready,
    input  cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, lkp_ready,
           rsp_valid, rsp_hit, rsp_idx, rsp_attr
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata, lkp_valid, lkp_addr, rsp_ready,
    output cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, lkp_ready,
           rsp_valid, rsp_hit, rsp_idx, rsp_attr
  );
endinterface

// File: rtl/pma_region_table_match.sv
// Single-rule range check; subtract-then-compare avoids base+length overflow.
module pma_region_table_match #(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic                 valid,
  output logic                 hit
);
  logic [AddrWidth-1:0] offset;

  assign offset = addr - base;
  assign hit    = valid && (addr >= base) && (offset < length);
endmodule

// File: rtl/pma_region_table.sv
// PMA rule table: reg-port programming plus a one-stage, lowest-index-wins lookup.
module pma_region_table
  import pma_region_table_pkg::*;
#(
  parameter int                           NrRules     = 8,
  parameter int                           AddrWidth   = 64,
  parameter int                           DataWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0] ResetBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] ResetLength = '0,
  parameter logic [NrRules*8-1:0]         ResetCtrl   = '0,
  parameter logic [2:0]                   DefaultAttr = 3'b000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pma_region_table_if.slave bus
);
  localparam int              IdxW     = (NrRules > 1) ? $clog2(NrRules) : 1;
  localparam logic [IdxW:0]   NrRulesW = NrRules[IdxW:0];

  logic      [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
  pma_ctrl_t [NrRules-1:0]                ctrl_q;

  logic [IdxW-1:0]      cfg_idx;
  pma_field_e           cfg_field;
  logic                 idx_ok, cfg_bad, wr_en;
  logic [DataWidth-1:0] rd_val;
  logic                 rvalid_q, err_q;
  logic [DataWidth-1:0] rdata_q;

  assign cfg_idx   = bus.cfg_addr[IdxW+1:2];
  assign cfg_field = pma_field_e'(bus.cfg_addr[1:0]);
  assign idx_ok    = ({1'b0, cfg_idx} < NrRulesW);

  always_comb begin
    rd_val  = '0;
    cfg_bad = 1'b0;
    if (!idx_ok || cfg_field == FIELD_RSVD) begin
      cfg_bad = 1'b1;
    end else if (bus.cfg_we) begin
      cfg_bad = ctrl_q[cfg_idx][CTRL_LOCK_BIT];
    end else begin
      case (cfg_field)
        FIELD_BASE:   rd_val = DataWidth'(base_q[cfg_idx]);
        FIELD_LENGTH: rd_val = DataWidth'(len_q[cfg_idx]);
        FIELD_CTRL:   rd_val = DataWidth'(ctrl_q[cfg_idx]);
        default:      rd_val = '0;
      endcase
    end
  end

  assign wr_en       = bus.cfg_req && bus.cfg_we && !cfg_bad;
  assign bus.cfg_gnt = bus.cfg_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= ResetBase;
      len_q  <= ResetLength;
      for (int i = 0; i < NrRules; i++) ctrl_q[i] <= pma_ctrl_t'(ResetCtrl[i*8 +: 8] & CTRL_WMASK);
    end else if (wr_en) begin
      case (cfg_field)
        FIELD_BASE:   base_q[cfg_idx] <= bus.cfg_wdata[AddrWidth-1:0];
        FIELD_LENGTH: len_q[cfg_idx]  <= bus.cfg_wdata[AddrWidth-1:0];
        FIELD_CTRL:   ctrl_q[cfg_idx] <= pma_ctrl_t'(bus.cfg_wdata[7:0] & CTRL_WMASK);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.cfg_req;
      err_q    <= bus.cfg_req && cfg_bad;
      rdata_q  <= (bus.cfg_req && !bus.cfg_we) ? rd_val : '0;
    end
  end

  assign bus.cfg_rvalid = rvalid_q;
  assign bus.cfg_err    = err_q;
  assign bus.cfg_rdata  = rdata_q;

  logic [NrRules-1:0] rule_hit;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    pma_region_table_match #(.AddrWidth(AddrWidth)) u_match (
      .addr   (bus.lkp_addr),
      .base   (base_q[g]),
      .length (len_q[g]),
      .valid  (ctrl_q[g].valid),
      .hit    (rule_hit[g])
    );
  end

  logic            hit_d;
  logic [IdxW-1:0] idx_d;
  pma_attr_t       attr_d;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit_d  = 1'b0;
    idx_d  = '0;
    attr_d = pma_attr_t'(DefaultAttr);
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (rule_hit[i]) begin
        hit_d  = 1'b1;
        idx_d  = IdxW'(i);
        attr_d = ctrl2attr(ctrl_q[i]);
      end
    end
  end

  logic            rsp_valid_q, rsp_hit_q, accept;
  logic [IdxW-1:0] rsp_idx_q;
  pma_attr_t       rsp_attr_q;

  assign bus.lkp_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.lkp_valid && bus.lkp_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_attr_q  <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= hit_d;
      rsp_idx_q   <= idx_d;
      rsp_attr_q  <= attr_d;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.rsp_attr  = rsp_attr_q;
endmodule
